// File: rtl/imem_program_loader.sv
// imem_program_loader
//   Writer side of the MCU instruction-memory interface. Accepts framed bytes
//   (SYNC, LEN, ADDR, LEN data bytes, CSUM) over a valid/ready stream. Each data
//   byte is written into instruction memory, and the frame checksum is verified.
//   The MCU is held in reset until a frame loads with a good checksum. The
//   frame's start address is then presented as the boot PC.
//
//   Optional build macro: LOADER_TIMEOUT_EN
//     When it is defined, an inter-byte timeout of TIMEOUT_CYCLES aborts a
//     frame in progress and moves the loader to the error state.
module imem_program_loader #(
   parameter int unsigned                ADDR_WIDTH     = 8,
   parameter int unsigned                DATA_WIDTH     = 8,
   parameter logic [DATA_WIDTH-1:0]      SYNC_BYTE      = 8'hA5,
   parameter int unsigned                TIMEOUT_CYCLES = 1024
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [DATA_WIDTH-1:0] im_wdata,
   output logic                  cpu_hold,
   output logic [ADDR_WIDTH-1:0] boot_pc,
   output logic                  done,
   output logic                  error
);

   // One extra bit so that LEN=0 can be held as the full 2**ADDR_WIDTH count
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_ADDR,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      count, count_nxt;
   logic [DATA_WIDTH-1:0] sum, sum_nxt;
   logic [DATA_WIDTH-1:0] sum_add;
   logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
   logic [ADDR_WIDTH-1:0] frame_addr, frame_addr_nxt;
   logic                  we_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [DATA_WIDTH-1:0] wdata_nxt;
   logic                  hold_nxt;
   logic [ADDR_WIDTH-1:0] boot_nxt;
   logic                  done_nxt;
   logic                  error_nxt;
   logic                  xfer;
   logic                  is_sync;

`ifdef LOADER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0]      tmo_cnt, tmo_cnt_nxt;
`endif

   assign xfer    = s_valid && s_ready;
   assign is_sync = (s_data == SYNC_BYTE);
   assign sum_add = sum + s_data;

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus next values for the datapath and the outputs
   always_comb begin
      state_nxt      = state;
      count_nxt      = count;
      sum_nxt        = sum;
      wr_ptr_nxt     = wr_ptr;
      frame_addr_nxt = frame_addr;
      we_nxt         = 1'b0;
      addr_nxt       = im_addr;
      wdata_nxt      = im_wdata;
      hold_nxt       = cpu_hold;
      boot_nxt       = boot_pc;
      done_nxt       = done;
      error_nxt      = error;
`ifdef LOADER_TIMEOUT_EN
      tmo_cnt_nxt    = '0;
`endif

      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (xfer && is_sync) begin
               state_nxt = ST_LEN;
               done_nxt  = 1'b0;
               error_nxt = 1'b0;
               hold_nxt  = 1'b1;
            end
         end

         ST_LEN: begin
            if (xfer) begin
               count_nxt = (s_data == '0) ? CNT_W'(2 ** ADDR_WIDTH) : CNT_W'(s_data);
               sum_nxt   = s_data;
               state_nxt = ST_ADDR;
            end
         end

         ST_ADDR: begin
            if (xfer) begin
               wr_ptr_nxt     = ADDR_WIDTH'(s_data);
               frame_addr_nxt = ADDR_WIDTH'(s_data);
               sum_nxt        = sum_add;
               state_nxt      = ST_DATA;
            end
         end

         ST_DATA: begin
            if (xfer) begin
               we_nxt     = 1'b1;
               addr_nxt   = wr_ptr;
               wdata_nxt  = s_data;
               wr_ptr_nxt = wr_ptr + 1'b1;
               sum_nxt    = sum_add;
               count_nxt  = count - 1'b1;
               if (count == CNT_W'(1)) begin
                  state_nxt = ST_CSUM;
               end
            end
         end

         ST_CSUM: begin
            if (xfer) begin
               if (sum_add == '0) begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
                  error_nxt = 1'b0;
                  hold_nxt  = 1'b0;
                  boot_nxt  = frame_addr;
               end else begin
                  state_nxt = ST_ERR;
                  done_nxt  = 1'b0;
                  error_nxt = 1'b1;
                  hold_nxt  = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

`ifdef LOADER_TIMEOUT_EN
      // Counts idle cycles inside a frame; an accepted byte always restarts it
      if (state == ST_LEN || state == ST_ADDR || state == ST_DATA || state == ST_CSUM) begin
         if (xfer) begin
            tmo_cnt_nxt = '0;
         end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_nxt = '0;
            state_nxt   = ST_ERR;
            done_nxt    = 1'b0;
            error_nxt   = 1'b1;
            hold_nxt    = 1'b1;
         end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
         end
      end
`endif
   end

   // Datapath and registered outputs
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s_ready    <= 1'b0;
         count      <= '0;
         sum        <= '0;
         wr_ptr     <= '0;
         frame_addr <= '0;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         cpu_hold   <= 1'b1;
         boot_pc    <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         s_ready    <= 1'b1;
         count      <= count_nxt;
         sum        <= sum_nxt;
         wr_ptr     <= wr_ptr_nxt;
         frame_addr <= frame_addr_nxt;
         im_we      <= we_nxt;
         im_addr    <= addr_nxt;
         im_wdata   <= wdata_nxt;
         cpu_hold   <= hold_nxt;
         boot_pc    <= boot_nxt;
         done       <= done_nxt;
         error      <= error_nxt;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   // Inter-byte timeout counter
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader
//   Directed-vector bench for imem_program_loader. It records instruction-memory
//   writes as they appear and compares them, together with the status outputs,
//   against hand-computed values for each frame.
module tb_imem_program_loader;

   logic       Clk;
   logic       Reset;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       im_we;
   logic [7:0] im_addr;
   logic [7:0] im_wdata;
   logic       cpu_hold;
   logic [7:0] boot_pc;
   logic       done;
   logic       error;

   int unsigned vectors;
   int unsigned miscompares;
   int unsigned cyc;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  d;
      int unsigned c;
   } wr_t;

   wr_t wq[$];

   imem_program_loader #(
      .ADDR_WIDTH    (8),
      .DATA_WIDTH    (8),
      .SYNC_BYTE     (8'hA5),
      .TIMEOUT_CYCLES(1024)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .im_we   (im_we),
      .im_addr (im_addr),
      .im_wdata(im_wdata),
      .cpu_hold(cpu_hold),
      .boot_pc (boot_pc),
      .done    (done),
      .error   (error)
   );

   // 10 ns clock
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Cycle counter used to timestamp writes
   always @(posedge Clk) cyc++;

   // Capture memory writes half a cycle after the edge that produced them
   always @(negedge Clk) begin
      if (im_we) wq.push_back('{im_addr, im_wdata, cyc});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input int unsigned gap);
      repeat (gap) @(negedge Clk);
      @(negedge Clk);
      s_data  = b;
      s_valid = 1'b1;
      @(posedge Clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic apply_reset();
      Reset   = 1'b0;
      s_valid = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
   endtask

   task automatic check_resets(input string tag);
      check({tag, ".s_ready"},  {31'd0, s_ready},  32'd0);
      check({tag, ".im_we"},    {31'd0, im_we},    32'd0);
      check({tag, ".im_addr"},  {24'd0, im_addr},  32'd0);
      check({tag, ".im_wdata"}, {24'd0, im_wdata}, 32'd0);
      check({tag, ".cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
      check({tag, ".boot_pc"},  {24'd0, boot_pc},  32'd0);
      check({tag, ".done"},     {31'd0, done},     32'd0);
      check({tag, ".error"},    {31'd0, error},    32'd0);
   endtask

   task automatic check_write(input string tag, input int unsigned idx,
                              input logic [7:0] a, input logic [7:0] d);
      if (idx < wq.size()) begin
         check({tag, ".addr"}, {24'd0, wq[idx].a}, {24'd0, a});
         check({tag, ".data"}, {24'd0, wq[idx].d}, {24'd0, d});
         if (idx > 0)
            check({tag, ".cyc"}, wq[idx].c - wq[idx-1].c, 32'd1);
      end else begin
         check({tag, ".present"}, 32'd0, 32'd1);
      end
   endtask

   task automatic check_status(input string tag, input logic d, input logic e,
                               input logic h, input logic [7:0] pc);
      check({tag, ".done"},     {31'd0, done},     {31'd0, d});
      check({tag, ".error"},    {31'd0, error},    {31'd0, e});
      check({tag, ".cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
      check({tag, ".boot_pc"},  {24'd0, boot_pc},  {24'd0, pc});
   endtask

   task automatic send_t1(input logic [7:0] csum);
      send(8'hA5, 0); send(8'h03, 0); send(8'h10, 0);
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
      send(csum, 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      Reset       = 1'b0;
      s_valid     = 1'b0;
      s_data      = 8'h00;

      // Reset values while reset is held
      repeat (2) @(posedge Clk);
      #1;
      check_resets("rst");
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      check("rst.s_ready_up", {31'd0, s_ready}, 32'd1);

      // Test 1: good three-byte frame at 10
      wq.delete();
      send_t1(8'h87);
      check("t1.nwr", wq.size(), 32'd3);
      check_write("t1.w0", 0, 8'h10, 8'h11);
      check_write("t1.w1", 1, 8'h11, 8'h22);
      check_write("t1.w2", 2, 8'h12, 8'h33);
      check_status("t1", 1'b1, 1'b0, 1'b0, 8'h10);

      // Test 2: same frame, bad checksum, from a fresh reset
      apply_reset();
      wq.delete();
      send_t1(8'h88);
      check("t2.nwr", wq.size(), 32'd3);
      check_write("t2.w2", 2, 8'h12, 8'h33);
      check_status("t2", 1'b0, 1'b1, 1'b1, 8'h00);

      // Test 3: address wrap from FF to 00, started from the error state
      wq.delete();
      send(8'hA5, 0); send(8'h02, 0); send(8'hFF, 0);
      send(8'hAA, 0); send(8'hBB, 0); send(8'h9A, 0);
      check("t3.nwr", wq.size(), 32'd2);
      check_write("t3.w0", 0, 8'hFF, 8'hAA);
      check_write("t3.w1", 1, 8'h00, 8'hBB);
      check_status("t3", 1'b1, 1'b0, 1'b0, 8'hFF);

      // Test 4: junk before sync, irregular valid gaps
      wq.delete();
      send(8'h00, 1); send(8'hFF, 3); send(8'h5A, 0); send(8'hA5, 2);
      send(8'h01, 1); send(8'h40, 3); send(8'hC3, 0); send(8'hFC, 2);
      check("t4.nwr", wq.size(), 32'd1);
      check_write("t4.w0", 0, 8'h40, 8'hC3);
      check_status("t4", 1'b1, 1'b0, 1'b0, 8'h40);
      send(8'hA5, 0);
      check("t4.resync.hold", {31'd0, cpu_hold}, 32'd1);
      check("t4.resync.done", {31'd0, done},     32'd0);

      // Test 5: reset dropped mid-frame takes effect without a clock edge
      apply_reset();
      wq.delete();
      send(8'hA5, 0); send(8'h03, 0); send(8'h10, 0);
      send(8'h11, 0); send(8'h22, 0);
      check("t5.we_before", {31'd0, im_we}, 32'd1);
      #1;
      Reset = 1'b0;
      #1;
      check_resets("t5.async");
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      wq.delete();
      send_t1(8'h87);
      check("t5.nwr", wq.size(), 32'd3);
      check_write("t5.w0", 0, 8'h10, 8'h11);
      check_status("t5", 1'b1, 1'b0, 1'b0, 8'h10);

      // Test 6: idle inside a frame
      apply_reset();
      send(8'hA5, 0); send(8'h03, 0);
`ifdef LOADER_TIMEOUT_EN
      repeat (1023) @(posedge Clk);
      #1;
      check("t6.err_early", {31'd0, error}, 32'd0);
      @(posedge Clk);
      #1;
      check_status("t6.timeout", 1'b0, 1'b1, 1'b1, 8'h00);
`else
      repeat (5000) @(posedge Clk);
      #1;
      check_status("t6.idle", 1'b0, 1'b0, 1'b1, 8'h00);
      wq.delete();
      send(8'h10, 0); send(8'h11, 0); send(8'h22, 0);
      send(8'h33, 0); send(8'h87, 0);
      check("t6.nwr", wq.size(), 32'd3);
      check_status("t6.finish", 1'b1, 1'b0, 1'b0, 8'h10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
